rob_wb_arbiter: RTL and testbench
=================================

// Module: rob_wb_arbiter
// PURPOSE
//  Writeback arbiter in front of the ROB's two writeback ports (wb0/wb1).
//  Collects finished results from NUM_FU functional units via valid/ready and
//  grants up to two per cycle in round-robin order. Drives registered wb0_*/wb1_*.
//  Counts cycles with more than two requesters, for performance analysis.
// PARAMETERS
//  NUM_FU        4  number of FU requesters (>=2)
//  FU_IDX_WIDTH  2  log2(NUM_FU)
//  ROB_IDX_WIDTH 5  ROB index width; must match the ROB
//  CNT_WIDTH     32 width of the conflict counter
// PORTS
//  clk            in  1                      clock
//  rst            in  1                      synchronous reset, active-high
//  flush          in  1                      pipeline flush; same cycle as ROB flush
//  fu_valid       in  NUM_FU                 FU i has a result
//  fu_rob_idx     in  NUM_FU*ROB_IDX_WIDTH   packed; slice i = FU i ROB index
//  fu_value       in  NUM_FU*`DATA_WIDTH     packed; slice i = FU i result
//  fu_exception   in  NUM_FU                 FU i result raised an exception
//  fu_ready       out NUM_FU                 combinational grant; transfer = valid&ready
//  wb0_valid      out 1                      to ROB wb0
//  wb0_rob_idx    out ROB_IDX_WIDTH          to ROB wb0
//  wb0_value      out `DATA_WIDTH            to ROB wb0
//  wb0_exception  out 1                      to ROB wb0
//  wb1_valid      out 1                      to ROB wb1
//  wb1_rob_idx    out ROB_IDX_WIDTH          to ROB wb1
//  wb1_value      out `DATA_WIDTH            to ROB wb1
//  wb1_exception  out 1                      to ROB wb1
//  conflict_cnt   out CNT_WIDTH              cycles with >2 fu_valid bits set
// BEHAVIOUR
//  - Reset (rst=1 at posedge): wb0/wb1_valid, idx, value and exception = 0.
//    rr_ptr = 0. conflict_cnt = 0. Reset overrides flush and all requests.
//  - fu_ready is forced to 0 while rst or flush is 1.
//  - State: rr_ptr[FU_IDX_WIDTH-1:0] holds the highest-priority FU.
//  - Scan order: rr_ptr, rr_ptr+1, ... wrapping mod NUM_FU.
//    - First valid FU found = grant A. Second valid FU found = grant B.
//    - fu_ready has at most two bits set, in the same cycle as the request.
//  - Latency is 1 cycle. At the next posedge:
//    - wb0_* <= slice of A; wb0_valid=1.
//    - wb1_* <= slice of B; wb1_valid=1 only if B exists.
//    - wb1_valid=1 never occurs with wb0_valid=0.
//    - With no grant, wb*_valid <= 0 and the data fields hold their old values.
//  - rr_ptr update:
//    - After a grant: rr_ptr <= (last granted index + 1) mod NUM_FU.
//    - No grant: rr_ptr unchanged.
//    - Starvation-free: a held request is granted within ceil(NUM_FU/2) cycles.
//  - Requester rule: while fu_valid=1 and fu_ready=0, the FU holds rob_idx, value
//    and exception stable. It may deassert only after the transfer.
//  - Flush=1 (rst=0) at posedge: wb*_valid <= 0, rr_ptr <= 0, no transfer.
//    conflict_cnt is not cleared.
//  - conflict_cnt += 1 when popcount(fu_valid)>2, counted even under flush.
//    It saturates at all-ones and never wraps.
//  - Two FUs with the same rob_idx is illegal upstream. The arbiter forwards both
//    unchanged, and the ROB's wb1 wins.
// TESTING  (NUM_FU=4)
//  - Reset: hold rst 2 cycles with fu_valid=1111 -> fu_ready=0000,
//    wb0/wb1_valid=0, conflict_cnt=0 after release.
//  - Single request: FU2 valid, idx=5, value=0xDEADBEEF, exc=0
//    -> fu_ready=0100 in the same cycle.
//    -> Next cycle: wb0_valid=1, idx=5, value=0xDEADBEEF; wb1_valid=0; rr_ptr=3.
//  - Saturation: fu_valid=1111 held for 4 cycles from rr_ptr=0
//    -> grants {0,1},{2,3},{0,1},{2,3}; conflict_cnt=4.
//  - Wrap: rr_ptr=3, fu_valid=1001, FU3 idx=7, FU0 idx=9
//    -> wb0 idx=7, wb1 idx=9 (exc passed through); rr_ptr=1.
//  - Flush: fu_valid=1111 with flush=1 -> fu_ready=0000.
//    -> Next cycle: wb*_valid=0, rr_ptr=0, conflict_cnt+1.
//  - Mid-operation reset: wb0_valid=1 and FUs still requesting, assert rst
//    -> next cycle all wb outputs 0, rr_ptr=0, conflict_cnt=0.

Source files
------------

// File: rtl/rob_wb_arbiter.sv
// Writeback arbiter feeding the ROB's two writeback ports.
// Collects FU results over valid/ready and grants up to two per cycle in
// round-robin order. The granted results appear one cycle later on the
// registered wb0/wb1 ports. A saturating counter records cycles that had
// more than two requesters.

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module rob_wb_arbiter #(
    parameter int unsigned NUM_FU        = 4,
    parameter int unsigned FU_IDX_WIDTH  = 2,
    parameter int unsigned ROB_IDX_WIDTH = 5,
    parameter int unsigned CNT_WIDTH     = 32
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              flush,
    input  logic [NUM_FU-1:0]                 fu_valid,
    input  logic [NUM_FU*ROB_IDX_WIDTH-1:0]   fu_rob_idx,
    input  logic [NUM_FU*`DATA_WIDTH-1:0]     fu_value,
    input  logic [NUM_FU-1:0]                 fu_exception,
    output logic [NUM_FU-1:0]                 fu_ready,
    output logic                              wb0_valid,
    output logic [ROB_IDX_WIDTH-1:0]          wb0_rob_idx,
    output logic [`DATA_WIDTH-1:0]            wb0_value,
    output logic                              wb0_exception,
    output logic                              wb1_valid,
    output logic [ROB_IDX_WIDTH-1:0]          wb1_rob_idx,
    output logic [`DATA_WIDTH-1:0]            wb1_value,
    output logic                              wb1_exception,
    output logic [CNT_WIDTH-1:0]              conflict_cnt
);

    localparam int unsigned DATA_W = `DATA_WIDTH;

    // Round-robin pointer: the FU with highest priority this cycle
    logic [FU_IDX_WIDTH-1:0]  rr_ptr_q, rr_ptr_d;

    // Registered writeback port 0
    logic                     wb0_valid_q, wb0_valid_d;
    logic [ROB_IDX_WIDTH-1:0] wb0_idx_q, wb0_idx_d;
    logic [DATA_W-1:0]        wb0_value_q, wb0_value_d;
    logic                     wb0_exc_q, wb0_exc_d;

    // Registered writeback port 1
    logic                     wb1_valid_q, wb1_valid_d;
    logic [ROB_IDX_WIDTH-1:0] wb1_idx_q, wb1_idx_d;
    logic [DATA_W-1:0]        wb1_value_q, wb1_value_d;
    logic                     wb1_exc_q, wb1_exc_d;

    // Saturating conflict counter
    logic [CNT_WIDTH-1:0]     conflict_cnt_q, conflict_cnt_d;

    // Grant decision for this cycle
    logic                     grant_a_vld, grant_b_vld;
    logic [FU_IDX_WIDTH-1:0]  grant_a_idx, grant_b_idx;
    logic [NUM_FU-1:0]        ready_c;
    int unsigned              scan_pos;
    logic [FU_IDX_WIDTH-1:0]  scan_sel;

    // Payload of the two granted FUs
    logic [ROB_IDX_WIDTH-1:0] sel_a_idx, sel_b_idx;
    logic [DATA_W-1:0]        sel_a_value, sel_b_value;
    logic                     sel_a_exc, sel_b_exc;

    // Pointer advance after a grant
    logic [FU_IDX_WIDTH-1:0]  last_grant;
    int unsigned              next_ptr;
    logic                     conflict_c;

    // Scan requesters from rr_ptr upward (wrapping) and pick the first two valid
    always_comb begin
        grant_a_vld = 1'b0;
        grant_b_vld = 1'b0;
        grant_a_idx = '0;
        grant_b_idx = '0;
        ready_c     = '0;
        scan_pos    = 0;
        scan_sel    = '0;
        if (!rst && !flush) begin
            for (int unsigned k = 0; k < NUM_FU; k++) begin
                scan_pos = 32'(rr_ptr_q) + k;
                if (scan_pos >= NUM_FU) begin
                    scan_pos = scan_pos - NUM_FU;
                end
                scan_sel = FU_IDX_WIDTH'(scan_pos);
                if (fu_valid[scan_sel]) begin
                    if (!grant_a_vld) begin
                        grant_a_vld = 1'b1;
                        grant_a_idx = scan_sel;
                    end else if (!grant_b_vld) begin
                        grant_b_vld = 1'b1;
                        grant_b_idx = scan_sel;
                    end
                end
            end
            if (grant_a_vld) begin
                ready_c[grant_a_idx] = 1'b1;
            end
            if (grant_b_vld) begin
                ready_c[grant_b_idx] = 1'b1;
            end
        end
    end

    assign fu_ready = ready_c;

    // Mux the granted FUs' payload slices out of the packed request buses
    always_comb begin
        sel_a_idx   = '0;
        sel_a_value = '0;
        sel_a_exc   = 1'b0;
        sel_b_idx   = '0;
        sel_b_value = '0;
        sel_b_exc   = 1'b0;
        for (int unsigned i = 0; i < NUM_FU; i++) begin
            if (FU_IDX_WIDTH'(i) == grant_a_idx) begin
                sel_a_idx   = fu_rob_idx[i*ROB_IDX_WIDTH +: ROB_IDX_WIDTH];
                sel_a_value = fu_value[i*DATA_W +: DATA_W];
                sel_a_exc   = fu_exception[i];
            end
            if (FU_IDX_WIDTH'(i) == grant_b_idx) begin
                sel_b_idx   = fu_rob_idx[i*ROB_IDX_WIDTH +: ROB_IDX_WIDTH];
                sel_b_value = fu_value[i*DATA_W +: DATA_W];
                sel_b_exc   = fu_exception[i];
            end
        end
    end

    // Next pointer is one past the last granted FU, wrapping at NUM_FU
    always_comb begin
        last_grant = grant_b_vld ? grant_b_idx : grant_a_idx;
        next_ptr   = 32'(last_grant) + 1;
        if (next_ptr >= NUM_FU) begin
            next_ptr = 0;
        end
    end

    // More than two simultaneous requesters, counted regardless of flush
    assign conflict_c = ($countones(fu_valid) > 2);

    // Next-state for pointer, writeback registers and counter
    always_comb begin
        rr_ptr_d       = rr_ptr_q;
        wb0_valid_d    = 1'b0;
        wb0_idx_d      = wb0_idx_q;
        wb0_value_d    = wb0_value_q;
        wb0_exc_d      = wb0_exc_q;
        wb1_valid_d    = 1'b0;
        wb1_idx_d      = wb1_idx_q;
        wb1_value_d    = wb1_value_q;
        wb1_exc_d      = wb1_exc_q;
        conflict_cnt_d = conflict_cnt_q;

        if (flush) begin
            rr_ptr_d = '0;
        end else if (grant_a_vld) begin
            wb0_valid_d = 1'b1;
            wb0_idx_d   = sel_a_idx;
            wb0_value_d = sel_a_value;
            wb0_exc_d   = sel_a_exc;
            if (grant_b_vld) begin
                wb1_valid_d = 1'b1;
                wb1_idx_d   = sel_b_idx;
                wb1_value_d = sel_b_value;
                wb1_exc_d   = sel_b_exc;
            end
            rr_ptr_d = FU_IDX_WIDTH'(next_ptr);
        end

        if (conflict_c && !(&conflict_cnt_q)) begin
            conflict_cnt_d = conflict_cnt_q + CNT_WIDTH'(1);
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q       <= '0;
            wb0_valid_q    <= 1'b0;
            wb0_idx_q      <= '0;
            wb0_value_q    <= '0;
            wb0_exc_q      <= 1'b0;
            wb1_valid_q    <= 1'b0;
            wb1_idx_q      <= '0;
            wb1_value_q    <= '0;
            wb1_exc_q      <= 1'b0;
            conflict_cnt_q <= '0;
        end else begin
            rr_ptr_q       <= rr_ptr_d;
            wb0_valid_q    <= wb0_valid_d;
            wb0_idx_q      <= wb0_idx_d;
            wb0_value_q    <= wb0_value_d;
            wb0_exc_q      <= wb0_exc_d;
            wb1_valid_q    <= wb1_valid_d;
            wb1_idx_q      <= wb1_idx_d;
            wb1_value_q    <= wb1_value_d;
            wb1_exc_q      <= wb1_exc_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign wb0_valid     = wb0_valid_q;
    assign wb0_rob_idx   = wb0_idx_q;
    assign wb0_value     = wb0_value_q;
    assign wb0_exception = wb0_exc_q;
    assign wb1_valid     = wb1_valid_q;
    assign wb1_rob_idx   = wb1_idx_q;
    assign wb1_value     = wb1_value_q;
    assign wb1_exception = wb1_exc_q;
    assign conflict_cnt  = conflict_cnt_q;

endmodule

// File: tb/tb_rob_wb_arbiter.sv
// Bench for rob_wb_arbiter: directed vector table, reset corners, then
// random traffic against a queue-based round-robin reference model. A second
// instance with a 3-bit counter exercises conflict counter saturation.

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module tb_rob_wb_arbiter;

    localparam int unsigned NF = 4;
    localparam int unsigned IW = 5;
    localparam int unsigned DW = `DATA_WIDTH;
    localparam int unsigned PW = 2;
    localparam int NV = 10;

    logic clk = 1'b0;
    logic rst, flush;
    logic [NF-1:0]    fu_valid, fu_exception;
    logic [NF*IW-1:0] fu_rob_idx;
    logic [NF*DW-1:0] fu_value;

    logic [NF-1:0] rdy_a, rdy_b;
    logic          v0_a, x0_a, v1_a, x1_a, v0_b, x0_b, v1_b, x1_b;
    logic [IW-1:0] i0_a, i1_a, i0_b, i1_b;
    logic [DW-1:0] d0_a, d1_a, d0_b, d1_b;
    logic [31:0]   cnt_a;
    logic [2:0]    cnt_b;

    int total = 0;
    int bad   = 0;

    rob_wb_arbiter dut (
        .clk(clk), .rst(rst), .flush(flush),
        .fu_valid(fu_valid), .fu_rob_idx(fu_rob_idx), .fu_value(fu_value),
        .fu_exception(fu_exception), .fu_ready(rdy_a),
        .wb0_valid(v0_a), .wb0_rob_idx(i0_a), .wb0_value(d0_a), .wb0_exception(x0_a),
        .wb1_valid(v1_a), .wb1_rob_idx(i1_a), .wb1_value(d1_a), .wb1_exception(x1_a),
        .conflict_cnt(cnt_a)
    );

    rob_wb_arbiter #(.CNT_WIDTH(3)) dut_s (
        .clk(clk), .rst(rst), .flush(flush),
        .fu_valid(fu_valid), .fu_rob_idx(fu_rob_idx), .fu_value(fu_value),
        .fu_exception(fu_exception), .fu_ready(rdy_b),
        .wb0_valid(v0_b), .wb0_rob_idx(i0_b), .wb0_value(d0_b), .wb0_exception(x0_b),
        .wb1_valid(v1_b), .wb1_rob_idx(i1_b), .wb1_value(d1_b), .wb1_exception(x1_b),
        .conflict_cnt(cnt_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NF-1:0]    valid;
        logic             flush;
        logic [NF*IW-1:0] idx;
        logic [NF*DW-1:0] val;
        logic [NF-1:0]    exc;
        logic [NF-1:0]    e_rdy;
        logic             e_v0;
        logic [IW-1:0]    e_i0;
        logic [DW-1:0]    e_d0;
        logic             e_x0;
        logic             e_v1;
        logic [IW-1:0]    e_i1;
        logic [DW-1:0]    e_d1;
        logic             e_x1;
        logic [PW-1:0]    e_ptr;
        logic [31:0]      e_cnt;
    } vec_t;

    vec_t tab [NV];

    // Reference model state
    int            m_ptr;
    logic          m_v0, m_x0, m_v1, m_x1;
    logic [IW-1:0] m_i0, m_i1;
    logic [DW-1:0] m_d0, m_d1;
    longint        m_cnt;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_fu(input int r, input int i, input logic [IW-1:0] ix,
                          input logic [DW-1:0] v, input logic x);
        logic [NF*IW-1:0] ib;
        logic [NF*DW-1:0] vb;
        logic [NF-1:0]    xb;
        ib = tab[r].idx;
        vb = tab[r].val;
        xb = tab[r].exc;
        ib[i*IW +: IW] = ix;
        vb[i*DW +: DW] = v;
        xb[i] = x;
        tab[r].idx = ib;
        tab[r].val = vb;
        tab[r].exc = xb;
    endtask

    task automatic set_exp(input int r, input logic [NF-1:0] rdy,
                           input logic v0, input logic [IW-1:0] i0, input logic [DW-1:0] d0, input logic x0,
                           input logic v1, input logic [IW-1:0] i1, input logic [DW-1:0] d1, input logic x1,
                           input logic [PW-1:0] ptr, input logic [31:0] cnt);
        tab[r].e_rdy = rdy;
        tab[r].e_v0 = v0; tab[r].e_i0 = i0; tab[r].e_d0 = d0; tab[r].e_x0 = x0;
        tab[r].e_v1 = v1; tab[r].e_i1 = i1; tab[r].e_d1 = d1; tab[r].e_x1 = x1;
        tab[r].e_ptr = ptr;
        tab[r].e_cnt = cnt;
    endtask

    // Ordered list of valid FUs starting at the model pointer; first two win
    task automatic model_grants(output logic [NF-1:0] mask, output int ga, output int gb);
        int order[$];
        mask = '0;
        ga = -1;
        gb = -1;
        if (!rst && !flush) begin
            for (int k = 0; k < int'(NF); k++) begin
                int f;
                f = (m_ptr + k) % int'(NF);
                if (fu_valid[f]) order.push_back(f);
            end
        end
        if (order.size() > 0) begin ga = order[0]; mask[ga] = 1'b1; end
        if (order.size() > 1) begin gb = order[1]; mask[gb] = 1'b1; end
    endtask

    task automatic model_clock(input int ga, input int gb);
        if (rst) begin
            m_ptr = 0; m_cnt = 0;
            m_v0 = 0; m_i0 = '0; m_d0 = '0; m_x0 = 0;
            m_v1 = 0; m_i1 = '0; m_d1 = '0; m_x1 = 0;
        end else begin
            if ($countones(fu_valid) > 2) m_cnt++;
            m_v0 = 0;
            m_v1 = 0;
            if (flush) begin
                m_ptr = 0;
            end else if (ga >= 0) begin
                m_v0 = 1;
                m_i0 = fu_rob_idx[ga*IW +: IW];
                m_d0 = fu_value[ga*DW +: DW];
                m_x0 = fu_exception[ga];
                if (gb >= 0) begin
                    m_v1 = 1;
                    m_i1 = fu_rob_idx[gb*IW +: IW];
                    m_d1 = fu_value[gb*DW +: DW];
                    m_x1 = fu_exception[gb];
                    m_ptr = (gb + 1) % int'(NF);
                end else begin
                    m_ptr = (ga + 1) % int'(NF);
                end
            end
        end
    endtask

    task automatic check_port(input string tag,
                              input logic v0, input logic [IW-1:0] i0, input logic [DW-1:0] d0, input logic x0,
                              input logic v1, input logic [IW-1:0] i1, input logic [DW-1:0] d1, input logic x1);
        check({tag, "_wb0_valid"}, 64'(v0), 64'(m_v0));
        check({tag, "_wb0_idx"},   64'(i0), 64'(m_i0));
        check({tag, "_wb0_value"}, 64'(d0), 64'(m_d0));
        check({tag, "_wb0_exc"},   64'(x0), 64'(m_x0));
        check({tag, "_wb1_valid"}, 64'(v1), 64'(m_v1));
        check({tag, "_wb1_idx"},   64'(i1), 64'(m_i1));
        check({tag, "_wb1_value"}, 64'(d1), 64'(m_d1));
        check({tag, "_wb1_exc"},   64'(x1), 64'(m_x1));
    endtask

    initial begin
        logic [NF-1:0] emask;
        int ga, gb;

        // Directed vector table, starting from rr_ptr=0 after reset
        for (int r = 0; r < NV; r++) tab[r] = '{default: '0};
        tab[0].valid = 4'b0100;
        set_fu(0, 2, 5'd5, 32'hDEADBEEF, 1'b0);
        set_exp(0, 4'b0100, 1, 5'd5, 32'hDEADBEEF, 0, 0, 5'd0, 32'h0, 0, 2'd3, 0);
        tab[1].valid = 4'b1001;
        set_fu(1, 3, 5'd7, 32'h33, 1'b1);
        set_fu(1, 0, 5'd9, 32'h99, 1'b0);
        set_exp(1, 4'b1001, 1, 5'd7, 32'h33, 1, 1, 5'd9, 32'h99, 0, 2'd1, 0);
        tab[2].valid = 4'b1111;
        tab[2].flush = 1'b1;
        for (int i = 0; i < 4; i++) set_fu(2, i, 5'(20 + i), 32'(32'h2000 + i), 1'b0);
        set_exp(2, 4'b0000, 0, 5'd7, 32'h33, 1, 0, 5'd9, 32'h99, 0, 2'd0, 1);
        for (int r = 3; r < NV; r++)
            for (int i = 0; i < 4; i++) set_fu(r, i, 5'(10 + i), 32'(32'h1000 + i), (i == 3));
        tab[3].valid = 4'b1111;
        set_exp(3, 4'b0011, 1, 5'd10, 32'h1000, 0, 1, 5'd11, 32'h1001, 0, 2'd2, 2);
        tab[4].valid = 4'b1111;
        set_exp(4, 4'b1100, 1, 5'd12, 32'h1002, 0, 1, 5'd13, 32'h1003, 1, 2'd0, 3);
        tab[5].valid = 4'b1111;
        set_exp(5, 4'b0011, 1, 5'd10, 32'h1000, 0, 1, 5'd11, 32'h1001, 0, 2'd2, 4);
        tab[6].valid = 4'b1111;
        set_exp(6, 4'b1100, 1, 5'd12, 32'h1002, 0, 1, 5'd13, 32'h1003, 1, 2'd0, 5);
        tab[7].valid = 4'b0000;
        set_exp(7, 4'b0000, 0, 5'd12, 32'h1002, 0, 0, 5'd13, 32'h1003, 1, 2'd0, 5);
        tab[8].valid = 4'b0110;
        set_exp(8, 4'b0110, 1, 5'd11, 32'h1001, 0, 1, 5'd12, 32'h1002, 0, 2'd3, 5);
        tab[9].valid = 4'b0001;
        set_exp(9, 4'b0001, 1, 5'd10, 32'h1000, 0, 0, 5'd12, 32'h1002, 0, 2'd1, 5);

        // Reset held two cycles with every FU requesting
        rst = 1'b1;
        flush = 1'b0;
        fu_valid = 4'b1111;
        fu_rob_idx = '1;
        fu_value = '1;
        fu_exception = '1;
        @(posedge clk); #1;
        check("rst_ready_c1", 64'(rdy_a), 64'(0));
        @(posedge clk); #1;
        check("rst_ready_c2", 64'(rdy_a), 64'(0));
        rst = 1'b0;
        fu_valid = '0;
        check("rst_wb0_valid", 64'(v0_a), 64'(0));
        check("rst_wb1_valid", 64'(v1_a), 64'(0));
        check("rst_cnt", 64'(cnt_a), 64'(0));
        check("rst_ptr", 64'(dut.rr_ptr_q), 64'(0));

        // Apply the vector table
        for (int r = 0; r < NV; r++) begin
            fu_valid = tab[r].valid;
            flush = tab[r].flush;
            fu_rob_idx = tab[r].idx;
            fu_value = tab[r].val;
            fu_exception = tab[r].exc;
            #1;
            check($sformatf("v%0d_ready", r), 64'(rdy_a), 64'(tab[r].e_rdy));
            @(posedge clk); #1;
            check($sformatf("v%0d_wb0_valid", r), 64'(v0_a), 64'(tab[r].e_v0));
            check($sformatf("v%0d_wb0_idx", r),   64'(i0_a), 64'(tab[r].e_i0));
            check($sformatf("v%0d_wb0_value", r), 64'(d0_a), 64'(tab[r].e_d0));
            check($sformatf("v%0d_wb0_exc", r),   64'(x0_a), 64'(tab[r].e_x0));
            check($sformatf("v%0d_wb1_valid", r), 64'(v1_a), 64'(tab[r].e_v1));
            check($sformatf("v%0d_wb1_idx", r),   64'(i1_a), 64'(tab[r].e_i1));
            check($sformatf("v%0d_wb1_value", r), 64'(d1_a), 64'(tab[r].e_d1));
            check($sformatf("v%0d_wb1_exc", r),   64'(x1_a), 64'(tab[r].e_x1));
            check($sformatf("v%0d_ptr", r),       64'(dut.rr_ptr_q), 64'(tab[r].e_ptr));
            check($sformatf("v%0d_cnt", r),       64'(cnt_a), 64'(tab[r].e_cnt));
        end
        flush = 1'b0;

        // Reset while wb0 is valid and all FUs still request
        check("midrst_pre_wb0_valid", 64'(v0_a), 64'(1));
        fu_valid = 4'b1111;
        rst = 1'b1;
        #1;
        check("midrst_ready", 64'(rdy_a), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        fu_valid = '0;
        m_ptr = 0; m_cnt = 0;
        m_v0 = 0; m_i0 = '0; m_d0 = '0; m_x0 = 0;
        m_v1 = 0; m_i1 = '0; m_d1 = '0; m_x1 = 0;
        check_port("midrst", v0_a, i0_a, d0_a, x0_a, v1_a, i1_a, d1_a, x1_a);
        check("midrst_ptr", 64'(dut.rr_ptr_q), 64'(0));
        check("midrst_cnt", 64'(cnt_a), 64'(0));
        check("midrst_cnt_s", 64'(cnt_b), 64'(0));

        // Random traffic; FUs hold payload until transferred
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 99) < 2);
            flush = !rst && ($urandom_range(0, 99) < 6);
            for (int i = 0; i < int'(NF); i++) begin
                if (!fu_valid[i] && $urandom_range(0, 99) < 55) begin
                    fu_valid[i] = 1'b1;
                    fu_rob_idx[i*IW +: IW] = IW'($urandom);
                    fu_value[i*DW +: DW] = DW'($urandom);
                    fu_exception[i] = 1'($urandom_range(0, 1));
                end
            end
            model_grants(emask, ga, gb);
            #1;
            check($sformatf("r%0d_ready", c), 64'(rdy_a), 64'(emask));
            check($sformatf("r%0d_ready_s", c), 64'(rdy_b), 64'(emask));
            @(posedge clk);
            model_clock(ga, gb);
            #1;
            check_port($sformatf("r%0d", c), v0_a, i0_a, d0_a, x0_a, v1_a, i1_a, d1_a, x1_a);
            check_port($sformatf("r%0d_s", c), v0_b, i0_b, d0_b, x0_b, v1_b, i1_b, d1_b, x1_b);
            check($sformatf("r%0d_ptr", c), 64'(dut.rr_ptr_q), 64'(m_ptr));
            check($sformatf("r%0d_cnt", c), 64'(cnt_a), 64'(m_cnt));
            check($sformatf("r%0d_cnt_sat", c), 64'(cnt_b), 64'((m_cnt > 7) ? 7 : m_cnt));
            fu_valid = fu_valid & ~emask;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
